// File: rtl/conv_encoder_k7_if.sv
// Stream interface for the K=7 convolutional encoder: an input bit stream
// and an output pair stream, each with a valid/ready handshake, plus a busy flag.
interface conv_encoder_k7_if;
  logic       in_valid;
  logic       in_bit;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_pair;
  logic       out_last;
  logic       out_ready;
  logic       busy;

  // Encoder side
  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_pair, out_last, busy
  );

  // Bit source / pair sink side
  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_pair, out_last, busy
  );
endinterface

// File: rtl/conv_encoder_k7.sv
// Rate-1/2 constraint-length-K convolutional encoder with optional zero tail.
// Emits one registered coded pair per accepted bit; with TAIL_EN it appends
// K-1 zero bits after in_last so every frame ends in encoder state 0.
module conv_encoder_k7 #(
  parameter int           K       = 7,
  parameter logic [K-1:0] G0      = 7'b1111001,
  parameter logic [K-1:0] G1      = 7'b1011011,
  parameter bit           TAIL_EN = 1'b1
) (
  input logic              clk,
  input logic              rst,
  conv_encoder_k7_if.slave enc_if
);

  localparam int         SR_W      = K - 1;
  localparam logic [2:0] TAIL_LAST = 3'(K - 2);

  typedef enum logic {
    ST_RUN,
    ST_TAIL
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        tail_cnt_q, tail_cnt_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [1:0]        out_pair_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              busy_q;

  logic              advance;
  logic              accept;
  logic              step;
  logic              u;
  logic              pair_last;
  logic              clear_sr;
  logic [K-1:0]      vec;
  logic              p0, p1;

  // Encoder vector {u, sr[0], ..., sr[SR_W-1]}: newest history bit next to u.
  function automatic logic [K-1:0] enc_vec(input logic u_in, input logic [SR_W-1:0] sr_in);
    logic [K-1:0] v;
    v[K-1] = u_in;
    for (int i = 0; i < SR_W; i++) v[K-2-i] = sr_in[i];
    return v;
  endfunction

  // The output register can take a new pair when empty or being drained.
  assign advance = !out_valid_q || enc_if.out_ready;
  assign accept  = enc_if.in_valid && enc_if.in_ready;

  assign enc_if.in_ready  = !rst && (state_q == ST_RUN) && advance;
  assign enc_if.out_valid = out_valid_q;
  assign enc_if.out_pair  = out_pair_q;
  assign enc_if.out_last  = out_last_q;
  assign enc_if.busy      = busy_q;

  // Parity of the step being taken this cycle.
  assign vec = enc_vec(u, sr_q);
  assign p0  = ^(G0 & vec);
  assign p1  = ^(G1 & vec);

  // Next-state logic: decide whether to encode, with which bit, and where to go.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    tail_cnt_d = tail_cnt_q;
    sr_d       = sr_q;
    step       = 1'b0;
    u          = 1'b0;
    pair_last  = 1'b0;
    clear_sr   = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (accept) begin
          step = 1'b1;
          u    = enc_if.in_bit;
          if (enc_if.in_last) begin
            if (TAIL_EN) begin
              state_d    = ST_TAIL;
              tail_cnt_d = 3'd0;
            end else begin
              // Truncated frame: close it here and restart from state 0.
              pair_last = 1'b1;
              clear_sr  = 1'b1;
            end
          end
        end
      end
      ST_TAIL: begin
        if (advance) begin
          step       = 1'b1;
          tail_cnt_d = tail_cnt_q + 3'd1;
          if (tail_cnt_q == TAIL_LAST) begin
            pair_last  = 1'b1;
            state_d    = ST_RUN;
            tail_cnt_d = 3'd0;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (step) sr_d = clear_sr ? '0 : {sr_q[SR_W-2:0], u};
  end

  // FSM and shift-register state.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_RUN;
      tail_cnt_q <= 3'd0;
      sr_q       <= '0;
    end else begin
      state_q    <= state_d;
      tail_cnt_q <= tail_cnt_d;
      sr_q       <= sr_d;
    end
  end

  // Output pair register and frame-in-progress flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_pair_q  <= 2'b00;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (step) begin
        out_pair_q  <= {p0, p1};
        out_valid_q <= 1'b1;
        out_last_q  <= pair_last;
      end else if (enc_if.out_ready) begin
        out_valid_q <= 1'b0;
      end

      // A new frame starting wins over the previous frame's last pair leaving.
      if (accept) busy_q <= 1'b1;
      else if (out_valid_q && enc_if.out_ready && out_last_q) busy_q <= 1'b0;
    end
  end

endmodule

// File: doc/conv_encoder_k7.md
Name: conv_encoder_k7

Overview:
- Rate-1/2, constraint-length-7 convolutional encoder.
- It is the transmit-side counterpart of the Viterbi decoder; its output pairs are the rx_pair symbols that the decoder's branch-metric units consume.
- Takes a framed serial bit stream over a valid/ready handshake and emits one 2-bit coded pair per input bit.
- Optionally appends K-1 zero tail bits so every frame terminates in state 0, which is what the decoder's traceback expects.

Parameters:
- K, 7, constraint length; the shift register holds K-1 = 6 bits.
- G0, 7'b1111001 (octal 171), generator for out_pair[1]; the MSB taps the current input bit.
- G1, 7'b1011011 (octal 133), generator for out_pair[0]; the MSB taps the current input bit.
- TAIL_EN, 1, 1 = append K-1 zero tail bits after in_last; 0 = truncated frame with no tail.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit is valid.
- in_bit  input  1  information bit.
- in_last  input  1  marks the final information bit of the frame; qualified by in_valid.
- in_ready  output  1  encoder accepts in_bit this cycle.
- out_valid  output  1  out_pair is valid.
- out_pair  output  2  coded pair: [1] = G0 parity, [0] = G1 parity.
- out_last  output  1  marks the final pair of the frame.
- out_ready  input  1  downstream accepts out_pair.
- busy  output  1  a frame is in progress (data accepted or tail pending).

Behaviour:
- **Shift register sr[5:0].** sr[0] is the most recent previous bit and sr[5] the oldest.
  - Encoder vector: v = {u, sr[0], sr[1], ..., sr[5]}, with u in the MSB position.
  - Parity: p0 = XOR(G0 & v), p1 = XOR(G1 & v).
  - On each encode step, sr <= {sr[4:0], u}.
- **FSM states.**
  - RUN: accepting data; this is the reset state.
  - TAIL: generating tail bits; only entered when TAIL_EN=1.
- **Output register.** One stage, holding out_pair, out_valid and out_last.
  - advance = !out_valid || out_ready.
  - When an encode step fires, the output register loads {p0,p1} with out_valid=1.
  - Otherwise, if out_ready is high, out_valid <= 0.
  - out_pair and out_last are held stable while out_valid && !out_ready.
- **in_ready.** Asserted as (state==RUN) && advance. It is combinational from out_valid, out_ready and state.
- **RUN.** On in_valid && in_ready, encode with u = in_bit.
  - Latency: the pair appears on out_valid the next cycle.
  - If in_last is high and TAIL_EN=1: go to TAIL and set tail_cnt = 0. out_last for this pair = 0.
  - If in_last is high and TAIL_EN=0: out_last = 1 and sr clears to 0 in the same update. The next frame starts from state 0.
- **TAIL.** Each cycle with advance=1, encode with u = 0 and increment tail_cnt (3 bits).
  - When tail_cnt == K-2, the loaded pair has out_last = 1, the next state is RUN and tail_cnt resets to 0.
  - After the K-1 tail steps, sr is all zeros.
  - in_ready = 0 throughout TAIL.
- **busy.**
  - Set when the first bit of a frame is accepted.
  - Cleared when a pair with out_last=1 is accepted downstream (out_valid && out_ready && out_last).
- **Pair count.**
  - Frame of N bits: exactly N + 6 pairs when TAIL_EN=1, N pairs when TAIL_EN=0.
  - No bubbles between pairs when out_ready is held high.
- **Back-to-back frames.**
  - A new frame's first bit can be accepted in the cycle after the final tail pair loads, provided advance holds.
  - With TAIL_EN=0, a new frame can be accepted in the very next cycle.
- **Reset.** rst has priority over all other activity, including mid-frame. It sets:
  - sr = 0, state = RUN, tail_cnt = 0;
  - out_valid = 0, out_pair = 2'b00, out_last = 0, busy = 0.
  - in_ready is 0 during the reset cycle and 1 in the first cycle after reset.
  - Any partial frame is discarded; no out_last is produced for it.
- **Ignored inputs.** in_bit and in_last are ignored whenever in_valid is low or in_ready is low.

Test Plan:
1. **Impulse.** TAIL_EN=1, out_ready=1, single bit 1 with in_last -> 7 pairs: 11,10,11,11,00,01,11. out_last only on the 7th pair, busy falls after it, first pair one cycle after acceptance.
2. **Known frame.** Bits 1,0,1,1 (last on the 4th) -> 10 pairs: 11,10,00,10,01,01,00,01,10,11. in_ready is low for the 6 tail cycles; out_last is on pair 10.
3. **Backpressure.** Repeat test 2 with out_ready toggled pseudo-randomly (e.g. a 1-of-3 stall pattern) -> the same 10-pair sequence with no pair dropped or duplicated, and out_pair stable during stalls.
4. **Back-to-back and all-zero.** An all-zero frame of 8 bits followed immediately by the impulse frame -> 14 pairs of 00, then the 7-pair impulse sequence. This shows the tail leaves state 0 and the frames are independent.
5. **No tail.** TAIL_EN=0, bits 1,0,1,1 with last -> 4 pairs: 11,10,00,10, out_last on the 4th. A following single bit 1 yields 11, confirming sr was cleared.
6. **Reset mid-tail.** Assert rst after pair 7 of test 2 -> next cycle out_valid=0, busy=0, in_ready=1, and no out_last. A new impulse frame then produces the exact sequence from test 1.
